// File: rtl/rgb2rgbw_conv_pkg.sv
// Shared definitions for the RGB -> RGBW converter: default channel width
// and the lane positions of each colour in the input and output words.
package rgb2rgbw_conv_pkg;

  localparam int CH_W_DEF = 8;

  // Input word lanes (lane 0 = LSBs): {.., R, G, B}
  localparam int IN_R_LANE = 2;
  localparam int IN_G_LANE = 1;
  localparam int IN_B_LANE = 0;

  // Output word lanes: {R', G', B', W}
  localparam int OUT_R_LANE = 3;
  localparam int OUT_G_LANE = 2;
  localparam int OUT_B_LANE = 1;
  localparam int OUT_W_LANE = 0;

endpackage

// File: rtl/rgbw_min3.sv
// Combinational unsigned minimum of three channel values.
module rgbw_min3 #(
  parameter int CH_W = 8
) (
  input  logic [CH_W-1:0] a,
  input  logic [CH_W-1:0] b,
  input  logic [CH_W-1:0] c,
  output logic [CH_W-1:0] y
);

  logic [CH_W-1:0] ab;

  // Two-level compare tree; ties resolve to an equal value, so order is irrelevant.
  always_comb begin
    ab = (a < b) ? a : b;
    y  = (ab < c) ? ab : c;
  end

endmodule

// File: rtl/rgb2rgbw_conv.sv
// RGB -> RGBW converter: pops RGB pixels from a show-ahead FIFO, extracts
// the common white component and hands {R',G',B',W} downstream over
// valid/ready. Two register stages: capture (p1) and compute (p2 = outputs).
// Optional feature macro: RGB2RGBW_BYPASS_EN adds a per-pixel `bypass`
// input that passes {R,G,B,0} through unchanged.
module rgb2rgbw_conv
  import rgb2rgbw_conv_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int CH_W      = CH_W_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic [DATA_SIZE-1:0] r_data,
  input  logic                 r_empty,
  output logic                 r_en,
  output logic [4*CH_W-1:0]    o_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [CNT_W-1:0]     pix_cnt
`ifdef RGB2RGBW_BYPASS_EN
  ,
  input  logic                 bypass
`endif
);

  logic              adv1;
  logic              adv2;
  logic              vld_p1;
  logic [CH_W-1:0]   r_p1;
  logic [CH_W-1:0]   g_p1;
  logic [CH_W-1:0]   b_p1;
  logic [CH_W-1:0]   w_p1;
  logic [4*CH_W-1:0] res_p1;
`ifdef RGB2RGBW_BYPASS_EN
  logic              byp_p1;
`endif

  // FIFO word bits above the three channels carry nothing for us.
  logic unused_hi;
  assign unused_hi = ^r_data[DATA_SIZE-1:3*CH_W];

  // Handshake: a stage may load when its successor can take what it holds.
  always_comb begin
    adv2 = !o_valid || o_ready;
    adv1 = !vld_p1 || adv2;
    r_en = !r_empty && adv1 && !r_rst;
  end

  // ---- stage p1: capture popped pixel ----
  // Stage 1 valid: set on a pop, cleared when it drains without a refill.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      vld_p1 <= 1'b0;
    end else if (r_en) begin
      vld_p1 <= 1'b1;
    end else if (adv1) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage 1 data: channel fields (and bypass flag) of the popped word.
  always_ff @(posedge r_clk) begin
    if (r_en) begin
      r_p1   <= r_data[IN_R_LANE*CH_W +: CH_W];
      g_p1   <= r_data[IN_G_LANE*CH_W +: CH_W];
      b_p1   <= r_data[IN_B_LANE*CH_W +: CH_W];
`ifdef RGB2RGBW_BYPASS_EN
      byp_p1 <= bypass;
`endif
    end
  end

  rgbw_min3 #(
    .CH_W (CH_W)
  ) u_min3 (
    .a (r_p1),
    .b (g_p1),
    .c (b_p1),
    .y (w_p1)
  );

  // White extraction: W is the minimum, so each subtraction stays non-negative.
  always_comb begin
    res_p1 = '0;
    res_p1[OUT_R_LANE*CH_W +: CH_W] = r_p1 - w_p1;
    res_p1[OUT_G_LANE*CH_W +: CH_W] = g_p1 - w_p1;
    res_p1[OUT_B_LANE*CH_W +: CH_W] = b_p1 - w_p1;
    res_p1[OUT_W_LANE*CH_W +: CH_W] = w_p1;
`ifdef RGB2RGBW_BYPASS_EN
    if (byp_p1) begin
      res_p1 = '0;
      res_p1[OUT_R_LANE*CH_W +: CH_W] = r_p1;
      res_p1[OUT_G_LANE*CH_W +: CH_W] = g_p1;
      res_p1[OUT_B_LANE*CH_W +: CH_W] = b_p1;
    end
`endif
  end

  // ---- stage p2: registered outputs ----
  // Output register: loads on advance; data only changes for a real pixel.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (adv2) begin
      o_valid <= vld_p1;
      if (vld_p1) begin
        o_data <= res_p1;
      end
    end
  end

  // Delivered-pixel counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      pix_cnt <= '0;
    end else if (o_valid && o_ready) begin
      pix_cnt <= pix_cnt + CNT_W'(1);
    end
  end

endmodule
